ram_burst_ctrl: RTL and testbench
=================================

# ram_burst_ctrl

Burst initiator for the RAM64_8 word store. It accepts a single command (start address, length, direction) and then does one of two things. On a write burst it streams words from a valid/ready source into the RAM. On a read burst it streams RAM words out to a valid/ready sink. It sits between CPU-side datapath logic and RAM64_8, and is the only block driving the RAM's data_in/addr/write_en.

## Interface
- WIDTH, `WORDSIZE (8): data word width; matches RAM64_8.
- DEPTH, 64: RAM words; addresses wrap modulo DEPTH.
- AW, 6: significant address bits (log2 DEPTH).

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- clr  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  start address.
- cmd_len  in  AW+1  word count 0..DEPTH; values > DEPTH treated as DEPTH.
- wr_data  in  WIDTH  write-stream word.
- wr_valid  in  1  write word present.
- wr_ready  out  1  write word consumed when wr_valid && wr_ready.
- rd_data  out  WIDTH  read-stream word (registered).
- rd_valid  out  1  read word present.
- rd_ready  in  1  sink accepts when rd_valid && rd_ready.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse at burst completion.
- ram_addr  out  `WORDSIZE  to RAM addr; upper bits zero.
- ram_data_in  out  WIDTH  to RAM data_in.
- ram_write_en  out  1  to RAM write_en.
- ram_data_out  in  WIDTH  from RAM data_out.

## Operation
RAM contract:
- Write commits on the rising clk edge while write_en is high.
- data_out is a combinational function of addr.

State machine: IDLE, WRITE, READ, DONE.
- **IDLE:** cmd_ready = 1. On accept, latch cur_addr = cmd_addr and remaining = min(cmd_len, DEPTH).
  - remaining == 0 -> DONE.
  - cmd_write -> WRITE.
  - otherwise -> READ.
- **WRITE:**
  - wr_ready = 1.
  - ram_addr = cur_addr, ram_data_in = wr_data.
  - ram_write_en = wr_valid && !clr.
  - On each handshake: cur_addr+1 mod DEPTH, remaining-1. Last handshake -> DONE.
  - No handshake: no RAM write, nothing advances.
- **READ:**
  - ram_addr = cur_addr; ram_write_en = 0.
  - Load slot when !rd_valid || rd_ready, and remaining > 0: rd_data <= ram_data_out, rd_valid <= 1, cur_addr+1, remaining-1.
  - Slot accepted and remaining == 0: rd_valid <= 0.
  - Leave -> DONE on the cycle the final word is accepted by the sink (rd_valid && rd_ready && remaining == 0).
- **DONE:** done = 1 for exactly this cycle, then -> IDLE.
- **Outside WRITE:** ram_write_en = 0 and wr_ready = 0. In IDLE and DONE, ram_addr holds cur_addr.
- **Address arithmetic:** AW-bit, wraps DEPTH-1 -> 0. Upper ram_addr bits are tied 0.

## Timing
Reset (clr high at an edge):
- state = IDLE, cur_addr = 0, remaining = 0, rd_data = 0, rd_valid = 0.
- Resulting outputs: cmd_ready = 1, busy = 0, done = 0, wr_ready = 0, ram_write_en = 0, ram_addr = 0.
- Reset mid-burst abandons the burst. No RAM write may occur on the edge where clr is high. No done pulse.

Write latency:
- Command accepted at edge N -> WRITE from cycle N+1.
- Sustains 1 word/cycle with wr_valid held high.
- Length-L burst with no stalls: done pulses in cycle N+L+1; cmd_ready returns in cycle N+L+2.

Read latency:
- First rd_valid in cycle N+2, i.e. one cycle after entering READ.
- Sustains 1 word/cycle with rd_ready held high.
- Back-pressure holds rd_data stable while rd_valid && !rd_ready.

Other timing rules:
- Length 0: done pulses in cycle N+1; no RAM or stream activity.
- cmd_valid outside IDLE is ignored: cmd_ready = 0, and the command must be held by the source.
- Length DEPTH from any start address touches every word exactly once, with wrap.

## Test plan
- Write burst, addr 0, len 4, data 10,12,2,3, then read burst addr 0 len 4 with rd_ready = 1 -> rd_data 10,12,2,3 on consecutive cycles; one done per burst.
- Wrap: write addr 62 len 3 data 7,8,9 -> RAM[62] = 7, RAM[63] = 8, RAM[0] = 9; read addr 62 len 3 returns 7,8,9.
- Stalls: wr_valid alternating 1/0 on a len 4 write, and rd_ready alternating 0/1 on the readback -> no lost or duplicated words; rd_data stable while stalled.
- clr asserted on the third beat of a len 8 write -> RAM addr 2 and above unchanged; next cycle busy = 0, cmd_ready = 1, rd_valid = 0, no done.
- len 0 command -> done pulse one cycle after accept; ram_write_en never high; rd_valid never high.
- cmd_len 100 (above DEPTH) read burst -> exactly 64 words delivered.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: single-command burst initiator for a RAM64_8-style word store.
// A command gives a start address, a length and a direction. A write burst moves words
// from a valid/ready source into the RAM. A read burst moves RAM words out to a
// valid/ready sink through a one-word registered slot.
//
// Ports:
//   clk, clr                  clock, synchronous active-high reset
//   cmd_valid/ready           command handshake; cmd_write, cmd_addr, cmd_len qualify it
//   wr_data/valid/ready       write-stream input
//   rd_data/valid/ready       read-stream output (rd_data registered)
//   busy, done                not idle; one-cycle completion pulse
//   ram_addr/data_in/write_en RAM drive; ram_data_out is the RAM's combinational read port
module ram_burst_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW:0]      cmd_len,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data_in,
  output logic             ram_write_en,
  input  logic [WIDTH-1:0] ram_data_out
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [AW:0]   LenMax   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] AddrLast = AW'(DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    cur_addr_q, cur_addr_d;
  logic [AW:0]      remaining_q, remaining_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic [AW:0]      len_clamped;
  logic [AW-1:0]    addr_inc;
  logic             rd_load;

  assign len_clamped = (cmd_len > LenMax) ? LenMax : cmd_len;
  // Explicit wrap keeps addressing correct even if DEPTH is not a power of two.
  assign addr_inc    = (cur_addr_q == AddrLast) ? '0 : cur_addr_q + 1'b1;
  // Slot can take a new word when empty or being drained this cycle.
  assign rd_load     = (!rd_valid_q || rd_ready) && (remaining_q != '0);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    ram_write_en = 1'b0;
    ram_data_in  = '0;
    done         = 1'b0;

    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = StDone;
          end else if (cmd_write) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end

      StWrite: begin
        wr_ready     = 1'b1;
        ram_data_in  = wr_data;
        // Gate with clr so a reset edge never commits a stray word.
        ram_write_en = wr_valid && !clr;
        if (wr_valid) begin
          cur_addr_d  = addr_inc;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (AW+1)'(1)) begin
            state_d = StDone;
          end
        end
      end

      StRead: begin
        if (rd_load) begin
          rd_data_d   = ram_data_out;
          rd_valid_d  = 1'b1;
          cur_addr_d  = addr_inc;
          remaining_d = remaining_q - 1'b1;
        end else if (rd_valid_q && rd_ready && (remaining_q == '0)) begin
          rd_valid_d = 1'b0;
          state_d    = StDone;
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ram_addr = {{(WIDTH - AW){1'b0}}, cur_addr_q};

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: a behavioural RAM, a transaction-level expected memory and
// scoreboard queues, one negedge compare process, and directed burst scenarios.
module tb_ram_burst_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr;
  logic [6:0] cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_ready;
  logic       busy, done;
  logic [7:0] ram_addr, ram_data_in, ram_data_out;
  logic       ram_write_en;

  always #5 clk = ~clk;

  ram_burst_ctrl #(.WIDTH(8), .DEPTH(64), .AW(6)) dut (
    .clk          (clk),
    .clr          (clr),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .done         (done),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_data_out (ram_data_out)
  );

  // Behavioural RAM64_8: write on rising edge, combinational read.
  logic [7:0] mem [64];
  logic       mem_init;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 3) + 64);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (ram_write_en) begin
      mem[ram_addr[5:0]] <= ram_data_in;
    end
  end
  assign ram_data_out = mem[ram_addr[5:0]];

  // Model state: expected memory contents and expected transfer queues.
  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] exp_mem [64];
  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] got_q[$];
  logic [7:0] wbuf [64];
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         rd_cnt = 0;
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin
    if (!mem_init) begin
      chk("busy_vs_cmd_ready", {31'b0, busy}, {31'b0, ~cmd_ready});
      if (ram_write_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_ram_write", 32'(ram_addr), 32'hFFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("ram_addr", 32'(ram_addr), {24'b0, 2'b00, w.a});
          chk("ram_data_in", 32'(ram_data_in), 32'(w.d));
        end
      end
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0) begin
          chk("unexpected_rd_word", 32'(rd_data), 32'hFFFF);
        end else begin
          logic [7:0] e;
          e = rq.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e));
        end
        got_q.push_back(rd_data);
        rd_cnt <= rd_cnt + 1;
      end
      if (stall_q) begin
        chk("rd_valid_held", {31'b0, rd_valid}, 32'd1);
        chk("rd_data_held", 32'(rd_data), 32'(stall_data));
      end
      stall_q    <= rd_valid && !rd_ready && !clr;
      stall_data <= rd_data;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [6:0] l);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Write burst of wbuf[0..l-1]; stall=1 drives wr_valid 1,0,1,0...
  task automatic wr_burst(input logic [5:0] a, input int l, input bit stall);
    int   dc0;
    int   i;
    int   k;
    logic v;
    dc0 = done_cnt;
    i   = 0;
    k   = 1;
    send_cmd(1'b1, a, 7'(l));
    while (i < l && k < 200) begin
      v = stall ? (k % 2 == 1) : 1'b1;
      wr_valid = v;
      wr_data  = v ? wbuf[i] : 8'hEE;
      if (v) begin
        wq.push_back('{a: 6'((a + i) % 64), d: wbuf[i]});
        exp_mem[(a + i) % 64] = wbuf[i];
      end
      @(negedge clk);
      chk("wr_ready", {31'b0, wr_ready}, 32'd1);
      chk("done_during_write", {31'b0, done}, 32'd0);
      if (v) i++;
      @(posedge clk); #1;
      k++;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done_pulse", {31'b0, done}, 32'd1);
    chk("wr_busy_in_done", {31'b0, busy}, 32'd1);
    chk("wr_done_cycle", 32'(k), stall ? 32'(2 * l) : 32'(l + 1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    chk("wr_done_cleared", {31'b0, done}, 32'd0);
    chk("wr_queue_drained", 32'(wq.size()), 32'd0);
    chk("wr_one_done", 32'(done_cnt - dc0), 32'd1);
    @(posedge clk); #1;
  endtask

  // Read burst; stall=1 drives rd_ready 0,1,0,1... by cycle index.
  task automatic rd_burst(input logic [5:0] a, input logic [6:0] lraw, input bit stall);
    int dc0;
    int rc0;
    int l;
    int k;
    bit seen;
    l    = (lraw > 7'd64) ? 64 : int'(lraw);
    dc0  = done_cnt;
    rc0  = rd_cnt;
    seen = 1'b0;
    got_q.delete();
    for (int i = 0; i < l; i++) rq.push_back(exp_mem[(a + i) % 64]);
    send_cmd(1'b0, a, lraw);
    k = 1;
    while (!seen && k < 300) begin
      rd_ready = stall ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      if (k == 1) chk("rd_valid_cycle1", {31'b0, rd_valid}, 32'd0);
      if (k == 2 && l > 0) chk("rd_valid_cycle2", {31'b0, rd_valid}, 32'd1);
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("rd_done_seen", {31'b0, seen}, 32'd1);
    if (!stall) chk("rd_done_cycle", 32'(k), (l == 0) ? 32'd1 : 32'(l + 2));
    chk("rd_valid_in_done", {31'b0, rd_valid}, 32'd0);
    rd_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_cmd_ready_back", {31'b0, cmd_ready}, 32'd1);
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    chk("rd_word_count", 32'(rd_cnt - rc0), 32'(l));
    chk("rd_one_done", 32'(done_cnt - dc0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] lit [4];
    int         dc0;

    clr = 1'b1; mem_init = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0; mem_init = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("rst_write_en", {31'b0, ram_write_en}, 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1;

    // Basic write then readback at address 0.
    wbuf[0] = 8'd10; wbuf[1] = 8'd12; wbuf[2] = 8'd2; wbuf[3] = 8'd3;
    wr_burst(6'd0, 4, 1'b0);
    rd_burst(6'd0, 7'd4, 1'b0);
    lit[0] = 8'd10; lit[1] = 8'd12; lit[2] = 8'd2; lit[3] = 8'd3;
    chk("basic_got_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("basic_got_word", 32'(got_q[i]), 32'(lit[i]));

    // Wrap across the top of the address space.
    wbuf[0] = 8'd7; wbuf[1] = 8'd8; wbuf[2] = 8'd9;
    wr_burst(6'd62, 3, 1'b0);
    chk("wrap_mem62", 32'(mem[62]), 32'd7);
    chk("wrap_mem63", 32'(mem[63]), 32'd8);
    chk("wrap_mem0", 32'(mem[0]), 32'd9);
    rd_burst(6'd62, 7'd3, 1'b0);
    lit[0] = 8'd7; lit[1] = 8'd8; lit[2] = 8'd9;
    chk("wrap_got_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("wrap_got_word", 32'(got_q[i]), 32'(lit[i]));

    // Stalled write and back-pressured readback.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    wr_burst(6'd20, 4, 1'b1);
    rd_burst(6'd20, 7'd4, 1'b1);
    chk("stall_got_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) chk("stall_got_last", 32'(got_q[3]), 32'h44);

    // Reset on the third beat of a length-8 write from address 0.
    for (int i = 0; i < 8; i++) wbuf[i] = 8'(50 + i);
    dc0 = done_cnt;
    send_cmd(1'b1, 6'd0, 7'd8);
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = wbuf[k];
      if (k < 2) begin
        wq.push_back('{a: 6'(k), d: wbuf[k]});
        exp_mem[k] = wbuf[k];
      end else begin
        clr = 1'b1;
      end
      @(negedge clk);
      if (k == 2) chk("clr_no_write", {31'b0, ram_write_en}, 32'd0);
      @(posedge clk); #1;
    end
    clr = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy", {31'b0, busy}, 32'd0);
    chk("clr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("clr_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("clr_done", {31'b0, done}, 32'd0);
    chk("clr_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr_no_done_pulse", 32'(done_cnt - dc0), 32'd0);
    chk("clr_queue_drained", 32'(wq.size()), 32'd0);
    chk("clr_mem0", 32'(mem[0]), 32'd50);
    chk("clr_mem1", 32'(mem[1]), 32'd51);
    chk("clr_mem2", 32'(mem[2]), 32'd2);
    chk("clr_mem3", 32'(mem[3]), 32'd3);
    chk("clr_mem4", 32'(mem[4]), 32'(init_val(4)));
    @(posedge clk); #1;

    // Zero-length commands.
    wr_burst(6'd9, 0, 1'b0);
    rd_burst(6'd9, 7'd0, 1'b0);

    // Over-length read clamps to the full array, starting mid-array.
    rd_burst(6'd5, 7'd100, 1'b0);

    // Whole-memory comparison against the model.
    for (int i = 0; i < 64; i++) chk("final_mem", 32'(mem[i]), 32'(exp_mem[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
